fifo_flags: RTL and testbench
=============================

Name: fifo_flags

Overview:
- Synchronous FIFO buffer that produces the occupancy status flags consumed by the flow-control FSM: almost_full, full, almost_empty, empty.
- Sits between the data producer (writer) and the consumer (reader).
- The flow-control FSM watches the flags and throttles the producer.
- Also reports overflow and underflow protocol errors.

Parameters:
- DATA_WIDTH, 6, width of each data word.
- ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 4).
- ALMOST_FULL_TH, 3, count at or above which almost_full asserts (must be < DEPTH).
- ALMOST_EMPTY_TH, 1, count at or below which almost_empty asserts (must be > 0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data, sampled when push is accepted.
- pop  input  1  read request.
- data_out  output  DATA_WIDTH  read data.
- valid_out  output  1  data_out holds a popped word.
- full  output  1  count == DEPTH.
- almost_full  output  1  ALMOST_FULL_TH <= count < DEPTH.
- empty  output  1  count == 0.
- almost_empty  output  1  0 < count <= ALMOST_EMPTY_TH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- error_overflow  output  1  sticky: a push was attempted while full without a pop.
- error_underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (reset=1 at a clk edge):
  - wr_ptr, rd_ptr, count = 0.
  - empty=1; full, almost_full, almost_empty = 0.
  - data_out = 0, valid_out = 0, both error bits = 0.
  - Memory contents are don't-care.
  - Reset wins over push/pop in the same cycle, including mid-operation; any stored data is discarded.
- Pointers: ADDR_WIDTH bits, wrap naturally from DEPTH-1 to 0.
- Count: a separate register, ADDR_WIDTH+1 bits; it never exceeds DEPTH or goes below 0.
- Accept rules, evaluated on count before the edge:
  - Push accepted if count < DEPTH, or if count == DEPTH and pop is also accepted in the same cycle.
  - Pop accepted if count > 0.
  - Push while full with no pop: data dropped, pointers unchanged, error_overflow set to 1.
  - Pop while empty: ignored, error_underflow set to 1. A simultaneous push is still accepted (count 0 -> 1); the pushed word is not bypassed to the output.
  - Push and pop both accepted: count unchanged, both pointers advance.
- Flags: combinational decode of the count register only, so they reflect an operation the cycle after its edge. No combinational path from push/pop to any flag.
- Read data (default mode, no macro):
  - An accepted pop at edge N loads mem[rd_ptr] into data_out with valid_out=1, visible after edge N (one-cycle latency).
  - valid_out=0 in any cycle with no accepted pop; data_out then holds its last value.
- Error bits are sticky until reset.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally and valid_out = !empty.
  - pop acknowledges the currently shown word; the next word appears after the edge.
  - data_out is 0 when empty.
- Undefined: registered read with one-cycle latency as described in Behaviour.
- Flags, count and error behaviour are identical in both modes.

Test Plan:
- Reset check: hold reset 2 cycles with push=1, data_in=6'h3F -> empty=1, count=0, all other outputs 0; nothing is stored.
- Fill sequence: push 6'h01, 02, 03, 04 on consecutive cycles.
  - After 1st: empty=0, almost_empty=1.
  - After 3rd: almost_full=1.
  - After 4th: full=1, almost_full=0, count=4.
- Overflow: from full, push 6'h05 with pop=0 -> count stays 4, error_overflow=1. Four later pops return 01, 02, 03, 04, each valid_out one cycle after its pop, and empty=1 after the last.
- Simultaneous push+pop: at full, push 6'h0A while popping -> count stays 4, full stays 1, no error; the popped word is the oldest.
- Underflow and wrap: from empty, pop -> error_underflow=1, count=0. Then push/pop 10 words 6'h10..6'h19 one at a time -> each word reads back in order across pointer wrap; count toggles 1/0.
- FWFT build (FIFO_FWFT_EN defined): push 6'h2A -> the cycle after, data_out=6'h2A and valid_out=1 with no pop; pop -> valid_out=0 and empty=1 next cycle.

Source files
------------

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy flags and sticky overflow/underflow error bits.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_flags #(
  parameter int unsigned DATA_WIDTH      = 6,
  parameter int unsigned ADDR_WIDTH      = 2,
  parameter int unsigned ALMOST_FULL_TH  = 3,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error_overflow,
  output logic                  error_underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0]         AfTh     = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0]         AeTh     = CW'(ALMOST_EMPTY_TH);
  localparam logic [CW-1:0]         CntOne   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok, pop_ok;

  // Acceptance is judged on the registered count; a full FIFO still takes a
  // push when a pop frees a slot on the same edge.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != DepthCnt) || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push & ~push_ok);
    unf_d = unf_q | (pop & ~pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Flags decode the count register only, never push/pop directly.
  always_comb begin
    empty           = (count_q == '0);
    full            = (count_q == DepthCnt);
    almost_full     = (count_q >= AfTh) && !full;
    almost_empty    = (count_q != '0) && (count_q <= AeTh);
    count           = count_q;
    error_overflow  = ovf_q;
    error_underflow = unf_q;
  end

`ifdef FIFO_FWFT_EN
  always_comb begin
    data_out  = empty ? '0 : mem_q[rd_ptr_q];
    valid_out = !empty;
  end
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;

  always_comb begin
    data_out_d  = pop_ok ? mem_q[rd_ptr_q] : data_out_q;
    valid_out_d = pop_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  always_comb begin
    data_out  = data_out_q;
    valid_out = valid_out_q;
  end
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags; expected values are hand-computed constants.
module tb_fifo_flags;

  logic       clk;
  logic       reset;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic       almost_empty;
  logic [2:0] count;
  logic       error_overflow;
  logic       error_underflow;

  int total;
  int bad;

  fifo_flags dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .data_in         (data_in),
    .pop             (pop),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .full            (full),
    .almost_full     (almost_full),
    .empty           (empty),
    .almost_empty    (almost_empty),
    .count           (count),
    .error_overflow  (error_overflow),
    .error_underflow (error_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [5:0] d, input logic r);
    push    = p;
    data_in = d;
    pop     = r;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b1, 6'h3F, 1'b0);
    step();
    step();
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_af", 32'(almost_full), 32'd0);
    check_eq("rst_ae", 32'(almost_empty), 32'd0);
    check_eq("rst_dout", 32'(data_out), 32'd0);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_ovf", 32'(error_overflow), 32'd0);
    check_eq("rst_unf", 32'(error_underflow), 32'd0);
    reset = 1'b0;
    drive(1'b0, 6'h00, 1'b0);
    step();
    check_eq("rst_nothing_stored", 32'(count), 32'd0);

`ifdef FIFO_FWFT_EN
    drive(1'b1, 6'h2A, 1'b0);
    step();
    drive(1'b0, 6'h00, 1'b0);
    check_eq("fwft_dout", 32'(data_out), 32'h2A);
    check_eq("fwft_valid", 32'(valid_out), 32'd1);
    check_eq("fwft_count", 32'(count), 32'd1);
    step();
    check_eq("fwft_hold", 32'(data_out), 32'h2A);
    drive(1'b0, 6'h00, 1'b1);
    step();
    drive(1'b0, 6'h00, 1'b0);
    check_eq("fwft_pop_valid", 32'(valid_out), 32'd0);
    check_eq("fwft_pop_empty", 32'(empty), 32'd1);
    check_eq("fwft_pop_dout", 32'(data_out), 32'd0);
    drive(1'b0, 6'h00, 1'b1);
    step();
    drive(1'b0, 6'h00, 1'b0);
    check_eq("fwft_unf", 32'(error_underflow), 32'd1);
`else
    // Fill
    drive(1'b1, 6'h01, 1'b0);
    step();
    check_eq("fill1_empty", 32'(empty), 32'd0);
    check_eq("fill1_ae", 32'(almost_empty), 32'd1);
    drive(1'b1, 6'h02, 1'b0);
    step();
    check_eq("fill2_ae", 32'(almost_empty), 32'd0);
    check_eq("fill2_count", 32'(count), 32'd2);
    drive(1'b1, 6'h03, 1'b0);
    step();
    check_eq("fill3_af", 32'(almost_full), 32'd1);
    check_eq("fill3_full", 32'(full), 32'd0);
    drive(1'b1, 6'h04, 1'b0);
    step();
    check_eq("fill4_full", 32'(full), 32'd1);
    check_eq("fill4_af", 32'(almost_full), 32'd0);
    check_eq("fill4_count", 32'(count), 32'd4);

    // Overflow: dropped word must not disturb contents
    drive(1'b1, 6'h05, 1'b0);
    step();
    check_eq("ovf_count", 32'(count), 32'd4);
    check_eq("ovf_flag", 32'(error_overflow), 32'd1);
    check_eq("ovf_valid", 32'(valid_out), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 6'h00, 1'b1);
      step();
      check_eq("drain_valid", 32'(valid_out), 32'd1);
      check_eq("drain_data", 32'(data_out), 32'(i));
      check_eq("drain_count", 32'(count), 32'(4 - i));
    end
    check_eq("drain_empty", 32'(empty), 32'd1);
    drive(1'b0, 6'h00, 1'b0);
    step();
    check_eq("idle_valid", 32'(valid_out), 32'd0);
    check_eq("idle_hold", 32'(data_out), 32'h04);
    check_eq("ovf_sticky", 32'(error_overflow), 32'd1);

    // Reset mid-stream clears the sticky error, then simultaneous push+pop at full
    drive(1'b1, 6'h21, 1'b0);
    step();
    reset = 1'b1;
    drive(1'b1, 6'h22, 1'b1);
    step();
    reset = 1'b0;
    check_eq("rst2_count", 32'(count), 32'd0);
    check_eq("rst2_ovf", 32'(error_overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(8'h0B + i), 1'b0);
      step();
    end
    check_eq("refill_full", 32'(full), 32'd1);
    drive(1'b1, 6'h0A, 1'b1);
    step();
    check_eq("pp_count", 32'(count), 32'd4);
    check_eq("pp_full", 32'(full), 32'd1);
    check_eq("pp_ovf", 32'(error_overflow), 32'd0);
    check_eq("pp_valid", 32'(valid_out), 32'd1);
    check_eq("pp_data", 32'(data_out), 32'h0B);
    drive(1'b0, 6'h00, 1'b1);
    step();
    check_eq("pp_d1", 32'(data_out), 32'h0C);
    step();
    check_eq("pp_d2", 32'(data_out), 32'h0D);
    step();
    check_eq("pp_d3", 32'(data_out), 32'h0E);
    step();
    check_eq("pp_d4", 32'(data_out), 32'h0A);
    check_eq("pp_empty", 32'(empty), 32'd1);

    // Underflow, then push+pop on empty: push lands, no bypass
    step();
    check_eq("unf_flag", 32'(error_underflow), 32'd1);
    check_eq("unf_count", 32'(count), 32'd0);
    check_eq("unf_valid", 32'(valid_out), 32'd0);
    drive(1'b1, 6'h3C, 1'b1);
    step();
    check_eq("epp_count", 32'(count), 32'd1);
    check_eq("epp_valid", 32'(valid_out), 32'd0);
    drive(1'b0, 6'h00, 1'b1);
    step();
    check_eq("epp_data", 32'(data_out), 32'h3C);
    check_eq("epp_empty", 32'(empty), 32'd1);

    // Wrap: ten single-word round trips
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 6'(8'h10 + i), 1'b0);
      step();
      check_eq("wrap_cnt1", 32'(count), 32'd1);
      drive(1'b0, 6'h00, 1'b1);
      step();
      check_eq("wrap_valid", 32'(valid_out), 32'd1);
      check_eq("wrap_data", 32'(data_out), 32'(8'h10 + i));
      check_eq("wrap_cnt0", 32'(count), 32'd0);
    end
    drive(1'b0, 6'h00, 1'b0);
    step();
    check_eq("unf_sticky", 32'(error_underflow), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
